genaxis_pkt_scheduler: RTL

- Sequences the pseudo-random descriptor stream (length, channel, data, pause) from the LFSR generator into AXI-Stream master packets with inter-packet gaps.
- Sits between the generator and the AXIS output port of the traffic generator.
- Clamps descriptors into the configured min/max ranges and counts sent packets.
- Starts and stops traffic cleanly on a packet boundary under an enable.

---
 rtl/genaxis_pkg.sv | 14 +
 rtl/genaxis_clamp.sv | 21 ++
 rtl/genaxis_pkt_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/genaxis_pkg.sv
// Shared types and widths for the AXI-Stream packet scheduler.
package genaxis_pkg;

    localparam int LENGTH_W = 16;
    localparam int PAUSE_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        PAUSE = 2'd3
    } state_t;

endpackage

// File: rtl/genaxis_clamp.sv
// Combinational range clamp; an inverted range (lo > hi) resolves to lo.
module genaxis_clamp #(
    parameter int W = 16
) (
    input  logic [W-1:0] raw,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] result
);

    always_comb begin
        if (raw < lo || lo > hi) begin
            result = lo;
        end else if (raw > hi) begin
            result = hi;
        end else begin
            result = raw;
        end
    end

endmodule

// File: rtl/genaxis_pkt_scheduler.sv
// Turns clamped generator descriptors into AXI-Stream packets separated by pause gaps.
// Define GENAXIS_SEQ_DATA_EN to replace tdata with {pkt_count[15:0], beat index} for debug.
module genaxis_pkt_scheduler
    import genaxis_pkg::*;
#(
    parameter int ID_WIDTH   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic [15:0]           cntrl_min_length_i,
    input  logic [15:0]           cntrl_max_length_i,
    input  logic [ID_WIDTH-1:0]   cntrl_min_channel_i,
    input  logic [ID_WIDTH-1:0]   cntrl_max_channel_i,
    input  logic [31:0]           cntrl_min_pause_i,
    input  logic [31:0]           cntrl_max_pause_i,
    input  logic [15:0]           gen_length_i,
    input  logic [ID_WIDTH-1:0]   gen_channel_i,
    input  logic [DATA_WIDTH-1:0] gen_data_i,
    input  logic [31:0]           gen_pause_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tlast_o,
    output logic [ID_WIDTH-1:0]   m_axis_tid_o,
    output logic                  busy_o,
    output logic [31:0]           pkt_count_o
);

    state_t state, state_next;

    logic [LENGTH_W-1:0]   len_clamped;
    logic [LENGTH_W-1:0]   len_eff;
    logic [ID_WIDTH-1:0]   ch_clamped;
    logic [PAUSE_W-1:0]    pause_clamped;

    logic [LENGTH_W-1:0]   beat_cnt;
    logic [PAUSE_W-1:0]    pause_len;
    logic [PAUSE_W-1:0]    pause_cnt;
    logic [ID_WIDTH-1:0]   tid;
    logic [DATA_WIDTH-1:0] tdata;
    logic [31:0]           pkt_count;
    logic [DATA_WIDTH-1:0] first_data;
    logic [DATA_WIDTH-1:0] next_data;

    logic handshake;
    logic last_beat;

    genaxis_clamp #(.W(LENGTH_W)) u_clamp_length (
        .raw    (gen_length_i),
        .lo     (cntrl_min_length_i),
        .hi     (cntrl_max_length_i),
        .result (len_clamped)
    );

    genaxis_clamp #(.W(ID_WIDTH)) u_clamp_channel (
        .raw    (gen_channel_i),
        .lo     (cntrl_min_channel_i),
        .hi     (cntrl_max_channel_i),
        .result (ch_clamped)
    );

    genaxis_clamp #(.W(PAUSE_W)) u_clamp_pause (
        .raw    (gen_pause_i),
        .lo     (cntrl_min_pause_i),
        .hi     (cntrl_max_pause_i),
        .result (pause_clamped)
    );

    assign len_eff   = (len_clamped == '0) ? LENGTH_W'(1) : len_clamped;
    assign last_beat = (beat_cnt == '0);
    assign handshake = (state == SEND) && m_axis_tready_i;

`ifdef GENAXIS_SEQ_DATA_EN
    logic [15:0] beat_idx;

    assign first_data = DATA_WIDTH'({pkt_count[15:0], 16'd0});
    assign next_data  = DATA_WIDTH'({pkt_count[15:0], beat_idx + 16'd1});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_idx <= '0;
        end else if (state == LOAD) begin
            beat_idx <= '0;
        end else if (handshake && !last_beat) begin
            beat_idx <= beat_idx + 16'd1;
        end
    end
`else
    assign first_data = gen_data_i;
    assign next_data  = gen_data_i;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // enable_i only matters when leaving IDLE or when the next packet would start
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable_i) state_next = LOAD;
            end
            LOAD: begin
                state_next = SEND;
            end
            SEND: begin
                if (handshake && last_beat) begin
                    if (pause_len != '0)  state_next = PAUSE;
                    else if (enable_i)    state_next = LOAD;
                    else                  state_next = IDLE;
                end
            end
            PAUSE: begin
                if (pause_cnt == '0) state_next = enable_i ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output beat register: only advances on a handshake, so it holds through stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt  <= '0;
            pause_len <= '0;
            pause_cnt <= '0;
            tid       <= '0;
            tdata     <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                LOAD: begin
                    beat_cnt  <= len_eff - LENGTH_W'(1);
                    pause_len <= pause_clamped;
                    tid       <= ch_clamped;
                    tdata     <= first_data;
                end
                SEND: begin
                    if (handshake) begin
                        if (!last_beat) begin
                            beat_cnt <= beat_cnt - LENGTH_W'(1);
                            tdata    <= next_data;
                        end else begin
                            pkt_count <= pkt_count + 32'd1;
                            pause_cnt <= pause_len - PAUSE_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (pause_cnt != '0) pause_cnt <= pause_cnt - PAUSE_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid_o = (state == SEND);
    assign m_axis_tlast_o  = (state == SEND) && last_beat;
    assign m_axis_tdata_o  = tdata;
    assign m_axis_tid_o    = tid;
    assign busy_o          = (state != IDLE);
    assign pkt_count_o     = pkt_count;

endmodule
